// File: rtl/mx_int_block_sum_stream_if.sv
// Beat/result bundle between the MX block unpacker and the block-sum stage.
// Latency: none, wires only.
// Backpressure: o_ready gates input beats, i_ready gates the result.
interface mx_int_block_sum_stream_if #(
   parameter int LANES       = 4,
   parameter int ELEM_WIDTH  = 8,
   parameter int SCALE_WIDTH = 8
);
   logic                        i_valid;
   logic                        o_ready;
   logic [SCALE_WIDTH-1:0]      i_scale;
   logic [LANES*ELEM_WIDTH-1:0] i_elements;
   logic                        o_valid;
   logic                        i_ready;
   logic [31:0]                 o_float32;
   logic                        o_overflow;

   // Block side: consumes beats and produces the float32 result.
   modport slave (
      input  i_valid, i_scale, i_elements, i_ready,
      output o_ready, o_valid, o_float32, o_overflow
   );

   // Environment side: sends beats and takes the result.
   modport master (
      output i_valid, i_scale, i_elements, i_ready,
      input  o_ready, o_valid, o_float32, o_overflow
   );
endinterface

// File: rtl/mx_int_block_sum_stream.sv
// Sums one MX integer block exactly, streamed as BLOCK_SIZE/LANES beats, and emits it as float32.
// Latency: result registered one NORM cycle after the last beat; block period BEATS+2 cycles.
// Backpressure: beats are taken only in ACC; the result is held in OUT until i_ready.
module mx_int_block_sum_stream #(
   parameter int ELEM_WIDTH  = 8,
   parameter int BLOCK_SIZE  = 32,
   parameter int LANES       = 4,
   parameter int SCALE_WIDTH = 8
) (
   input logic                     clk,
   input logic                     rst_n,
   mx_int_block_sum_stream_if.slave bus
);
   localparam int FRAC  = ELEM_WIDTH - 2;
   localparam int BEATS = BLOCK_SIZE / LANES;
   localparam int ACC_W = ELEM_WIDTH + $clog2(BLOCK_SIZE);
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   // Sums wider than 25 bits would no longer fit a 24-bit significand exactly.
   if (ACC_W > 25) begin : g_acc_too_wide
      $error("mx_int_block_sum_stream: ACC_W must be <= 25");
   end
   if ((BLOCK_SIZE % LANES) != 0) begin : g_bad_lanes
      $error("mx_int_block_sum_stream: BLOCK_SIZE must be a multiple of LANES");
   end

   typedef enum logic [1:0] {ST_ACC, ST_NORM, ST_OUT} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic [SCALE_WIDTH-1:0]   scale_q, scale_d;
   logic [31:0]              f32_q, f32_d;
   logic                     ovf_q, ovf_d;

   logic signed [ACC_W-1:0]  lane_sum;
   logic [ACC_W-1:0]         mag;
   logic [4:0]               msb_pos;
   logic signed [15:0]       exp_s;
   logic [22:0]              mant;
   logic                     sign;
   logic [31:0]              conv_f32;
   logic                     conv_ovf;

   // Sign-extend every lane of the current beat and add them up.
   always_comb begin
      lane_sum = '0;
      for (int k = 0; k < LANES; k++) begin
         lane_sum = lane_sum + {{(ACC_W-ELEM_WIDTH){bus.i_elements[k*ELEM_WIDTH+ELEM_WIDTH-1]}},
                                bus.i_elements[k*ELEM_WIDTH +: ELEM_WIDTH]};
      end
   end

   // Exact integer-to-float32 conversion of the accumulated sum with the shared scale.
   always_comb begin
      sign    = acc_q[ACC_W-1];
      mag     = sign ? (~acc_q + 1'b1) : acc_q;
      msb_pos = '0;
      for (int i = 0; i < ACC_W; i++) begin
         if (mag[i]) msb_pos = 5'(i);
      end
      exp_s = $signed(16'(scale_q) + 16'(msb_pos) - 16'(FRAC));
      mant  = 23'({mag, 23'b0} >> msb_pos);
      conv_ovf = 1'b0;
      if (scale_q == '1) begin
         conv_f32 = 32'h7FC0_0000;
      end else if (acc_q == '0) begin
         conv_f32 = 32'h0000_0000;
      end else if (exp_s >= 16'sd255) begin
         conv_f32 = sign ? 32'hFF80_0000 : 32'h7F80_0000;
         conv_ovf = 1'b1;
      end else if (exp_s <= 16'sd0) begin
         conv_f32 = {sign, 31'b0};
      end else begin
         conv_f32 = {sign, exp_s[7:0], mant};
      end
   end

   // Next-state and datapath updates for ACC -> NORM -> OUT -> ACC.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      scale_d = scale_q;
      f32_d   = f32_q;
      ovf_d   = ovf_q;
      case (state_q)
         ST_ACC: begin
            if (bus.i_valid) begin
               if (cnt_q == '0) begin
                  acc_d   = lane_sum;
                  scale_d = bus.i_scale;
               end else begin
                  acc_d = acc_q + lane_sum;
               end
               if (cnt_q == CNT_W'(BEATS-1)) begin
                  cnt_d   = '0;
                  state_d = ST_NORM;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         ST_NORM: begin
            f32_d   = conv_f32;
            ovf_d   = conv_ovf;
            state_d = ST_OUT;
         end
         ST_OUT: begin
            if (bus.i_ready) state_d = ST_ACC;
         end
         default: state_d = ST_ACC;
      endcase
   end

   // State registers; reset discards any partial block or pending result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACC;
         cnt_q   <= '0;
         acc_q   <= '0;
         scale_q <= '0;
         f32_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         scale_q <= scale_d;
         f32_q   <= f32_d;
         ovf_q   <= ovf_d;
      end
   end

   assign bus.o_ready    = (state_q == ST_ACC);
   assign bus.o_valid    = (state_q == ST_OUT);
   assign bus.o_float32  = f32_q;
   assign bus.o_overflow = ovf_q;
endmodule

// File: tb/tb_mx_int_block_sum_stream.sv
// Directed bench for the streaming MX block sum: table of blocks plus stall/reset sequences.
// Latency: checks NORM then OUT after the last beat and a BEATS+2 block period.
// Backpressure: exercises input idles, held results and ignored beats while busy.
module tb_mx_int_block_sum_stream;
   localparam int BEATS = 8;
   localparam int LANES = 4;

   logic clk;
   logic rst_n;
   int   n_cmp  = 0;
   int   n_fail = 0;
   int   cyc    = 0;
   int   xfer_cnt = 0;

   mx_int_block_sum_stream_if #(.LANES(4), .ELEM_WIDTH(8), .SCALE_WIDTH(8)) bus();

   mx_int_block_sum_stream #(
      .ELEM_WIDTH(8), .BLOCK_SIZE(32), .LANES(4), .SCALE_WIDTH(8)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      string       name;
      logic [7:0]  scale;
      logic [7:0]  fill;   // value of elements 1..31
      logic [7:0]  e0;     // value of element 0
      logic [31:0] exp_f;
      logic        exp_o;
   } vec_t;

   vec_t tbl[17];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle counter and count of accepted beats.
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst_n && bus.i_valid && bus.o_ready) xfer_cnt = xfer_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one beat from a negedge and return at the negedge after it transferred.
   task automatic put_beat(input logic [7:0] scale, input logic [7:0] fill, input logic [7:0] e0,
                           input int b, input bit junk);
      int guard;
      logic [31:0] el;
      for (int k = 0; k < LANES; k++) el[k*8 +: 8] = (b == 0 && k == 0) ? e0 : fill;
      bus.i_valid    = 1'b1;
      bus.i_elements = el;
      bus.i_scale    = (b != 0 && junk) ? 8'($urandom_range(0, 255)) : scale;
      guard = 0;
      while (!bus.o_ready && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 100) begin
         n_cmp++;
         n_fail++;
         $display("FAIL beat_timeout: o_ready low %0d cycles, required high", guard);
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
   endtask

   task automatic run_block(input logic [7:0] scale, input logic [7:0] fill, input logic [7:0] e0,
                            input bit stall, input bit junk, output int first_cyc);
      first_cyc = 0;
      for (int b = 0; b < BEATS; b++) begin
         if (stall) repeat ($urandom_range(0, 2)) @(negedge clk);
         put_beat(scale, fill, e0, b, junk);
         if (b == 0) first_cyc = cyc;
      end
   endtask

   // Called at the negedge after the last-beat edge: expect NORM, then OUT with the result.
   task automatic check_result(input string name, input logic [31:0] exp_f, input logic exp_o);
      chk({name, "_norm_valid"}, {31'b0, bus.o_valid}, 32'd0);
      chk({name, "_norm_ready"}, {31'b0, bus.o_ready}, 32'd0);
      @(negedge clk);
      chk({name, "_valid"}, {31'b0, bus.o_valid}, 32'd1);
      chk({name, "_ready"}, {31'b0, bus.o_ready}, 32'd0);
      chk({name, "_f32"}, bus.o_float32, exp_f);
      chk({name, "_ovf"}, {31'b0, bus.o_overflow}, {31'b0, exp_o});
   endtask

   initial begin
      int fc, prev_fc, x0;
      tbl[0]  = '{"all40",     8'd127, 8'h40, 8'h40, 32'h4200_0000, 1'b0};
      tbl[1]  = '{"e0_min",    8'd127, 8'h00, 8'h80, 32'hC000_0000, 1'b0};
      tbl[2]  = '{"all_min",   8'd127, 8'h80, 8'h80, 32'hC280_0000, 1'b0};
      tbl[3]  = '{"ovf_pos",   8'd254, 8'h7F, 8'h7F, 32'h7F80_0000, 1'b1};
      tbl[4]  = '{"nan",       8'hFF,  8'h40, 8'h40, 32'h7FC0_0000, 1'b0};
      tbl[5]  = '{"nan_zero",  8'hFF,  8'h00, 8'h00, 32'h7FC0_0000, 1'b0};
      tbl[6]  = '{"flush_pos", 8'd0,   8'h01, 8'h01, 32'h0000_0000, 1'b0};
      tbl[7]  = '{"flush_neg", 8'd0,   8'hFF, 8'hFF, 32'h8000_0000, 1'b0};
      tbl[8]  = '{"zero",      8'd127, 8'h00, 8'h00, 32'h0000_0000, 1'b0};
      tbl[9]  = '{"one_lsb",   8'd127, 8'h00, 8'h01, 32'h3C80_0000, 1'b0};
      tbl[10] = '{"all_m1",    8'd127, 8'hFF, 8'hFF, 32'hBF00_0000, 1'b0};
      tbl[11] = '{"mant",      8'd127, 8'h00, 8'h7F, 32'h3FFE_0000, 1'b0};
      tbl[12] = '{"e254",      8'd249, 8'h40, 8'h40, 32'h7F00_0000, 1'b0};
      tbl[13] = '{"e255",      8'd250, 8'h40, 8'h40, 32'h7F80_0000, 1'b1};
      tbl[14] = '{"e1",        8'd2,   8'h01, 8'h01, 32'h0080_0000, 1'b0};
      tbl[15] = '{"ovf_neg",   8'd254, 8'h80, 8'h80, 32'hFF80_0000, 1'b1};
      tbl[16] = '{"e0_flush",  8'd1,   8'h01, 8'h01, 32'h0000_0000, 1'b0};

      rst_n          = 1'b0;
      bus.i_valid    = 1'b0;
      bus.i_ready    = 1'b1;
      bus.i_scale    = '0;
      bus.i_elements = '0;
      #2;
      chk("rst_valid", {31'b0, bus.o_valid}, 32'd0);
      chk("rst_ready", {31'b0, bus.o_ready}, 32'd1);
      chk("rst_f32", bus.o_float32, 32'd0);
      chk("rst_ovf", {31'b0, bus.o_overflow}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Table of blocks, back to back with i_ready held high.
      prev_fc = 0;
      for (int i = 0; i < 17; i++) begin
         run_block(tbl[i].scale, tbl[i].fill, tbl[i].e0, 1'b0, 1'b0, fc);
         check_result(tbl[i].name, tbl[i].exp_f, tbl[i].exp_o);
         if (i > 0) chk({tbl[i].name, "_period"}, 32'(fc - prev_fc), 32'(BEATS + 2));
         prev_fc = fc;
      end

      // Random input idles and junk scale on later beats.
      for (int i = 0; i < 4; i++) begin
         run_block(tbl[i].scale, tbl[i].fill, tbl[i].e0, 1'b1, 1'b1, fc);
         check_result({"stall_", tbl[i].name}, tbl[i].exp_f, tbl[i].exp_o);
      end

      // Hold the result for 5 cycles while junk beats are offered.
      @(negedge clk);
      bus.i_ready = 1'b0;
      run_block(tbl[11].scale, tbl[11].fill, tbl[11].e0, 1'b0, 1'b0, fc);
      check_result("hold", tbl[11].exp_f, tbl[11].exp_o);
      x0 = xfer_cnt;
      for (int c = 0; c < 5; c++) begin
         bus.i_valid    = 1'b1;
         bus.i_elements = 32'h7F7F_7F7F;
         bus.i_scale    = 8'd200;
         @(negedge clk);
         chk("hold_valid", {31'b0, bus.o_valid}, 32'd1);
         chk("hold_ready", {31'b0, bus.o_ready}, 32'd0);
         chk("hold_f32", bus.o_float32, tbl[11].exp_f);
      end
      bus.i_valid = 1'b0;
      chk("hold_no_xfer", 32'(xfer_cnt - x0), 32'd0);
      bus.i_ready = 1'b1;
      @(negedge clk);
      chk("release_valid", {31'b0, bus.o_valid}, 32'd0);
      chk("release_ready", {31'b0, bus.o_ready}, 32'd1);
      run_block(tbl[9].scale, tbl[9].fill, tbl[9].e0, 1'b0, 1'b0, fc);
      check_result("after_hold", tbl[9].exp_f, tbl[9].exp_o);

      // Reset while a result is pending.
      @(negedge clk);
      bus.i_ready = 1'b0;
      run_block(tbl[3].scale, tbl[3].fill, tbl[3].e0, 1'b0, 1'b0, fc);
      check_result("pre_rst", tbl[3].exp_f, tbl[3].exp_o);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_out_valid", {31'b0, bus.o_valid}, 32'd0);
      chk("rst_out_f32", bus.o_float32, 32'd0);
      chk("rst_out_ovf", {31'b0, bus.o_overflow}, 32'd0);
      chk("rst_out_ready", {31'b0, bus.o_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset after three beats of a block; the next block must not see them.
      for (int b = 0; b < 3; b++) put_beat(8'd127, 8'h7F, 8'h7F, b, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", {31'b0, bus.o_valid}, 32'd0);
      chk("rst_mid_f32", bus.o_float32, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.i_ready = 1'b1;
      run_block(tbl[0].scale, tbl[0].fill, tbl[0].e0, 1'b0, 1'b0, fc);
      check_result("after_rst", tbl[0].exp_f, tbl[0].exp_o);

      @(negedge clk);
      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
